// File: rtl/pc_gen_pkg.sv
// Shared constants and state encoding for the fetch program-counter generator.
// Imported by the interface and by the pc_gen top.
package pc_gen_pkg;

    localparam int unsigned REG_BUS_W   = 32;
    localparam int unsigned INST_ADDR_W = 32;

    localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [INST_ADDR_W-1:0] PC_STEP          = 32'd4;

    // Reset is asserted when rst equals this level.
    localparam logic RST_ENABLE = 1'b0;

    typedef enum logic {
        PC_IDLE    = 1'b0,
        PC_PENDING = 1'b1
    } pc_state_e;

endpackage : pc_gen_pkg

// File: rtl/pc_gen_if.sv
// Control/redirect bundle between the pipeline and the program-counter generator.
// The pipeline side is master; pc_gen is the slave that owns the fetch PC.
interface pc_gen_if;
    import pc_gen_pkg::*;

    logic                   stall_i;
    logic                   branch_flag_i;
    logic [INST_ADDR_W-1:0] branch_target_i;
    logic                   flush_i;
    logic [INST_ADDR_W-1:0] new_pc_i;
    logic [INST_ADDR_W-1:0] pc_o;
    logic                   ce_o;
    logic                   redirect_o;
    logic                   pending_o;

    modport master (
        output stall_i, branch_flag_i, branch_target_i, flush_i, new_pc_i,
        input  pc_o, ce_o, redirect_o, pending_o
    );

    modport slave (
        input  stall_i, branch_flag_i, branch_target_i, flush_i, new_pc_i,
        output pc_o, ce_o, redirect_o, pending_o
    );

endinterface : pc_gen_if

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential advance, branch/flush redirect,
// and a one-entry latch that holds a branch resolved while fetch is stalled.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);

    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [INST_ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    pc_state_e              state_q, state_d;
    logic                   ce_q, ce_d;
    logic                   redirect_q, redirect_d;

    // NOTE: every signal gets a default before the priority chain, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        state_d    = state_q;
        ce_d       = 1'b1;
        redirect_d = 1'b0;

        if (!ce_q) begin
            // First edge out of reset only enables fetch; PC stays at RESET_PC.
        end else if (bus.flush_i) begin
            pc_d       = bus.new_pc_i;
            state_d    = PC_IDLE;
            redirect_d = 1'b1;
        end else if (bus.stall_i) begin
            if (bus.branch_flag_i) begin
                pend_tgt_d = bus.branch_target_i;
                state_d    = PC_PENDING;
            end
        end else if (bus.branch_flag_i) begin
            pc_d       = bus.branch_target_i;
            state_d    = PC_IDLE;
            redirect_d = 1'b1;
        end else if (state_q == PC_PENDING) begin
            pc_d       = pend_tgt_q;
            state_d    = PC_IDLE;
            redirect_d = 1'b1;
        end else begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
            state_q    <= PC_IDLE;
            ce_q       <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            state_q    <= state_d;
            ce_q       <= ce_d;
            redirect_q <= redirect_d;
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.ce_o       = ce_q;
    assign bus.redirect_o = redirect_q;
    assign bus.pending_o  = (state_q == PC_PENDING);

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_gen_if bus ();

    pc_gen #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the pending branch is a queue holding at most one target.
    logic [31:0] m_pc   = RST_PC;
    logic        m_ce   = 1'b0;
    logic        m_red  = 1'b0;
    logic [31:0] m_pend[$];
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic b,
                              input logic [31:0] bt, input logic f, input logic [31:0] np);
        if (!r) begin
            m_pc = RST_PC; m_ce = 1'b0; m_red = 1'b0; m_pend.delete();
        end else if (!m_ce) begin
            m_ce = 1'b1; m_red = 1'b0;
        end else if (f) begin
            m_pc = np; m_red = 1'b1; m_pend.delete();
        end else if (s) begin
            if (b) begin
                m_pend.delete();
                m_pend.push_back(bt);
            end
            m_red = 1'b0;
        end else if (b) begin
            m_pc = bt; m_red = 1'b1; m_pend.delete();
        end else if (m_pend.size() != 0) begin
            m_pc = m_pend.pop_front(); m_red = 1'b1;
        end else begin
            m_pc = m_pc + 32'd4; m_red = 1'b0;
        end
    endtask

    // Drive one cycle: inputs set away from the edge, model advanced at the edge,
    // return at the following falling edge where outputs are stable.
    task automatic cycle(input logic r, input logic s, input logic b,
                         input logic [31:0] bt, input logic f, input logic [31:0] np);
        rst                 = r;
        bus.stall_i         = s;
        bus.branch_flag_i   = b;
        bus.branch_target_i = bt;
        bus.flush_i         = f;
        bus.new_pc_i        = np;
        @(posedge clk);
        model_edge(r, s, b, bt, f, np);
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Single compare process against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pc",       bus.pc_o,       m_pc);
            check("model_ce",       {31'd0, bus.ce_o},       {31'd0, m_ce});
            check("model_redirect", {31'd0, bus.redirect_o}, {31'd0, m_red});
            check("model_pending",  {31'd0, bus.pending_o},  {31'd0, m_pend.size() != 0});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stall_i = 1'b0; bus.branch_flag_i = 1'b0; bus.branch_target_i = '0;
        bus.flush_i = 1'b0; bus.new_pc_i = '0;
        @(negedge clk);

        // Reset hold and release.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rst_pc", bus.pc_o, 32'hBFC0_0000);
        check("rst_ce", {31'd0, bus.ce_o}, 32'd0);
        idle(1);
        check("first_edge_ce", {31'd0, bus.ce_o}, 32'd1);
        check("first_edge_pc", bus.pc_o, 32'hBFC0_0000);
        idle(1);
        check("seq_pc4", bus.pc_o, 32'hBFC0_0004);
        idle(1);
        check("seq_pc8", bus.pc_o, 32'hBFC0_0008);
        idle(2);
        check("seq_pc10", bus.pc_o, 32'hBFC0_0010);

        // Unstalled branch.
        cycle(1'b1, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h0);
        check("br_pc", bus.pc_o, 32'h8000_0100);
        check("br_redirect", {31'd0, bus.redirect_o}, 32'd1);
        idle(1);
        check("br_next", bus.pc_o, 32'h8000_0104);

        // Branch resolved during a 4-cycle stall.
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h8000_0200, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("stall_hold", bus.pc_o, 32'h8000_0104);
        check("stall_pending", {31'd0, bus.pending_o}, 32'd1);
        idle(1);
        check("release_pc", bus.pc_o, 32'h8000_0200);
        check("release_pending", {31'd0, bus.pending_o}, 32'd0);
        check("release_redirect", {31'd0, bus.redirect_o}, 32'd1);

        // Flush beats stall, branch and pending.
        cycle(1'b1, 1'b1, 1'b1, 32'h8000_0200, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h8000_1234, 1'b1, 32'hBFC0_0380);
        check("flush_pc", bus.pc_o, 32'hBFC0_0380);
        check("flush_pending", {31'd0, bus.pending_o}, 32'd0);
        idle(1);
        check("flush_next", bus.pc_o, 32'hBFC0_0384);

        // Wrap and misaligned target.
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        idle(1);
        check("wrap", bus.pc_o, 32'h0000_0000);
        cycle(1'b1, 1'b0, 1'b1, 32'h8000_0102, 1'b0, 32'h0);
        check("misaligned", bus.pc_o, 32'h8000_0102);
        idle(1);
        check("misaligned_next", bus.pc_o, 32'h8000_0106);

        // Reset while a branch is pending.
        cycle(1'b1, 1'b1, 1'b1, 32'h8000_0300, 1'b0, 32'h0);
        check("pre_rst_pending", {31'd0, bus.pending_o}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("mid_rst_pending", {31'd0, bus.pending_o}, 32'd0);
        check("mid_rst_pc", bus.pc_o, 32'hBFC0_0000);
        idle(2);
        check("no_stale_target", bus.pc_o, 32'hBFC0_0004);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, b, f;
            logic [31:0] bt, np;
            r  = ($urandom_range(0, 199) != 0);
            s  = ($urandom_range(0, 9) < 4);
            b  = ($urandom_range(0, 9) < 2);
            f  = ($urandom_range(0, 29) == 0);
            bt = $urandom;
            np = $urandom;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) np[1:0] = 2'b00;
            if ($urandom_range(0, 49) == 0) bt = 32'hFFFF_FFF8;
            cycle(r, s, b, bt, f, np);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_gen

// File: doc/pc_gen.md
# pc_gen

Program-counter generator directly upstream of the instruction-fetch stage. Holds the fetch PC and drives the fetch stage's `addr`/`en`. Advances by 4 when the pipeline is not stalled. Redirects on decode-stage branches and on exception/ERET flushes, and latches a branch that resolves while fetch is stalled so it is never lost.

## Interface
Parameters:
- `RESET_PC`, `32'hBFC0_0000`, PC loaded on reset.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-low (asserted when `rst == 0`).
- `stall_i`  in  1  hold request from fetch stall OR any later-stage stall.
- `branch_flag_i`  in  1  single-cycle pulse from decode: taken branch/jump resolved; the instruction currently in fetch is its delay slot.
- `branch_target_i`  in  32  target for `branch_flag_i`.
- `flush_i`  in  1  exception/ERET redirect from CP0/commit.
- `new_pc_i`  in  32  redirect address for `flush_i`.
- `pc_o`  out  32  current fetch PC; drives fetch `addr`.
- `ce_o`  out  1  fetch enable; drives fetch `en`.
- `redirect_o`  out  1  registered; high for the one cycle after a non-sequential PC load.
- `pending_o`  out  1  high while a latched branch awaits release (debug/verification visibility).

## Operation
- Reset values (any edge with `rst == 0`): `pc_o = RESET_PC`, `ce_o = 0`, `redirect_o = 0`, `pending_o = 0`, pending target `= 0`. Reset mid-operation discards any pending branch.
- First edge with `rst == 1` sets `ce_o = 1`; `pc_o` stays at `RESET_PC` for that edge. Every later edge applies the rules below.
- State machine, two states:
  - IDLE (`pending_o = 0`).
  - PENDING (`pending_o = 1`, holds a 32-bit pending target).
- Per-edge priority, highest first:
  1. `flush_i`: `pc <= new_pc_i`; go to IDLE; `redirect_o <= 1`. Applies regardless of `stall_i` and `branch_flag_i`.
  2. `stall_i`: `pc` held. If `branch_flag_i`, load pending target with `branch_target_i` and go to PENDING. If already PENDING, the newer branch overwrites the target. `redirect_o <= 0`.
  3. Not stalled, `branch_flag_i`: `pc <= branch_target_i`; go to IDLE; `redirect_o <= 1`. A newer branch beats a pending one.
  4. Not stalled, PENDING: `pc <= pending target`; go to IDLE; `redirect_o <= 1`.
  5. Otherwise: `pc <= pc + 4`; `redirect_o <= 0`.
- Arithmetic: `pc + 4` is 32-bit and wraps modulo 2^32 (`FFFF_FFFC -> 0000_0000`).
- Targets and `new_pc_i` pass through unaltered, including misaligned values. The fetch stage raises the address-error exception; this block does not check alignment.
- Delay slots need no special handling: `branch_flag_i` arrives while the delay slot is in fetch, so the next PC is the target.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Redirect latency: one edge from a `flush_i` or unstalled `branch_flag_i` to `pc_o` showing the new address.
- A branch latched under stall appears on `pc_o` at the first edge where `stall_i == 0` and `flush_i == 0`.
- `stall_i` is sampled every cycle. A stall of N cycles holds `pc_o` for exactly N edges.
- `ce_o` stays 1 from the first post-reset edge until the next reset.

## Structure
- Shared package (`define.vh`): `RESET_PC` default, `RstEnable` level for the active-low reset, `RegBus`/`InstAddrBus` widths, and the two-state enum (`PC_IDLE`, `PC_PENDING`).
- No sub-module. The pending-branch latch is a 33-bit register (valid + target) kept inline.

## Test plan
- Reset release: hold `rst = 0` for 3 cycles, then 1 with no stalls. Expect `pc_o = BFC0_0000`/`ce_o = 0` during reset; `ce_o = 1` after the first edge; then `pc_o = BFC0_0004`, `BFC0_0008`.
- Unstalled branch: at `pc_o = BFC0_0010`, pulse `branch_flag_i` with target `8000_0100`. Expect `pc_o = 8000_0100` and `redirect_o = 1` at the next edge, then `8000_0104`.
- Branch during stall: `stall_i = 1` for 4 cycles; pulse `branch_flag_i` (target `8000_0200`) in cycle 2. Expect `pc_o` held and `pending_o = 1`; after stall drops, `pc_o = 8000_0200` and `pending_o = 0`.
- Flush beats everything: PENDING with target `8000_0200`, then `flush_i`, `stall_i` and `branch_flag_i` asserted together with `new_pc_i = BFC0_0380`. Expect `pc_o = BFC0_0380` and `pending_o = 0`.
- Wrap and misalignment: force `pc = FFFF_FFFC` unstalled, expect `0000_0000`. Branch to `8000_0102`, expect `pc_o = 8000_0102` unchanged.
- Reset mid-PENDING: assert `rst = 0` while `pending_o = 1`. Expect `pending_o = 0` and `pc_o = BFC0_0000`; after release, no stale branch target appears.
